nco_dout_serializer: RTL and testbench

- Downstream stage of the NCO top: takes each 12-bit Dout sample qualified by the Vld pulse from the output terminal.
- Buffers samples in a small FIFO and streams them off-chip over a narrow lane with a ready/valid handshake and a frame strobe, to save IO pins.
- Absorbs off-chip stalls; flags lost samples with a sticky overflow bit.

---
 rtl/nco_pkg.sv | 20 ++
 rtl/nco_sync_fifo.sv | 68 ++++++
 rtl/nco_dout_serializer.sv | 151 +++++++++++++++
 tb/tb_nco_dout_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_pkg
//  Description : Shared constants and types for the NCO output serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    localparam int DOUT_W = 12;              // NCO sample width
    localparam int LANE_W = 2;               // off-chip lane width per beat
    localparam int BEATS  = DOUT_W / LANE_W; // beats per sample word

    // Serializer control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nco_sync_fifo
//  Description : Pointer-based synchronous FIFO. A push into a full FIFO is
//                accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4    // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       push_ok_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wptr_q;
    logic [c_AW-1:0]  rptr_q;
    logic [c_CW-1:0]  count_q;

    logic w_rd;
    logic w_wr;

    assign full_o    = (count_q == c_CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_o = ~full_o | w_rd;
    assign w_rd      = pop_i & ~empty_o;
    assign w_wr      = push_i & push_ok_o;
    assign data_o    = mem_q[rptr_q];
    assign count_o   = count_q;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_wr) wptr_q <= wptr_q + 1'b1;
            if (w_rd) rptr_q <= rptr_q + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : nco_sync_fifo
`default_nettype wire

// File: rtl/nco_dout_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : nco_dout_serializer
//  Description : Buffers NCO Dout samples and streams them MSB-first over a
//                narrow ready/valid lane with a first-beat frame strobe.
//                Samples that find the FIFO full are dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_dout_serializer
    import nco_pkg::*;
#(
    parameter int DW    = DOUT_W,  // sample width
    parameter int LW    = LANE_W,  // lane width, DW must be a multiple of LW
    parameter int DEPTH = 4        // FIFO entries, power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       Vld,
    input  logic [DW-1:0]              Dout,
    input  logic                       Rdy,
    input  logic                       ClrOvf,
    output logic [LW-1:0]              Sdat,
    output logic                       Sval,
    output logic                       Sfrm,
    output logic                       Ovf,
    output logic [$clog2(DEPTH+1)-1:0] Lvl
);

    localparam int c_BEATS = DW / LW;
    localparam int c_BW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_CW    = $clog2(DEPTH+1);

    ser_state_e       state_q;
    logic [DW-1:0]    shreg_q;
    logic [c_BW-1:0]  beat_q;
    logic             sval_q;
    logic             sfrm_q;
    logic             ovf_q;
    logic             ovf_d;

    logic             w_xfer;
    logic             w_last;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic [DW-1:0]    w_fifo_data;
    logic [c_CW-1:0]  w_count;

    assign w_xfer = sval_q & Rdy;
    assign w_last = (beat_q == c_BW'(c_BEATS-1));

    // Pop when idle with data waiting, or on the final beat for a no-bubble reload
    assign w_pop  = ~w_empty & ((state_q == IDLE) |
                                ((state_q == SHIFT) & w_xfer & w_last));
    assign w_push = Vld & w_push_ok;
    assign w_drop = Vld & w_full & ~w_pop;

    nco_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (w_push),
        .pop_i     (w_pop),
        .data_i    (Dout),
        .data_o    (w_fifo_data),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_count),
        .push_ok_o (w_push_ok)
    );

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
    always_comb begin
        ovf_d = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (ClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Serializer FSM and shifter; outputs only change on a transfer or a load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            sval_q  <= 1'b0;
            sfrm_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        shreg_q <= w_fifo_data;
                        beat_q  <= '0;
                        sval_q  <= 1'b1;
                        sfrm_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_xfer) begin
                        if (w_last && !w_empty) begin
                            shreg_q <= w_fifo_data;
                            beat_q  <= '0;
                            sfrm_q  <= 1'b1;
                        end else if (w_last) begin
                            // Shifting out the last beat leaves the register clear
                            shreg_q <= {shreg_q[DW-LW-1:0], {LW{1'b0}}};
                            beat_q  <= '0;
                            sval_q  <= 1'b0;
                            sfrm_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            shreg_q <= {shreg_q[DW-LW-1:0], {LW{1'b0}}};
                            beat_q  <= beat_q + 1'b1;
                            sfrm_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sval_q  <= 1'b0;
                    sfrm_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Sdat = shreg_q[DW-1 -: LW];
    assign Sval = sval_q;
    assign Sfrm = sfrm_q;
    assign Ovf  = ovf_q;
    assign Lvl  = w_count;

endmodule : nco_dout_serializer
`default_nettype wire

// File: tb/tb_nco_dout_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_dout_serializer
//  Description : Directed self-checking bench for nco_dout_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nco_dout_serializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Vld;
    logic [11:0] Dout;
    logic        Rdy;
    logic        ClrOvf;
    logic [1:0]  Sdat;
    logic        Sval;
    logic        Sfrm;
    logic        Ovf;
    logic [2:0]  Lvl;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  exp1 [6]  = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
    logic [1:0]  exp2 [12] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                               2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [1:0]  exp3 [6]  = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [11:0] ws [8];

    always #5 clk = ~clk;

    nco_dout_serializer u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .Vld    (Vld),
        .Dout   (Dout),
        .Rdy    (Rdy),
        .ClrOvf (ClrOvf),
        .Sdat   (Sdat),
        .Sval   (Sval),
        .Sfrm   (Sfrm),
        .Ovf    (Ovf),
        .Lvl    (Lvl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] beat_of(input logic [11:0] w, input int b);
        beat_of = w[11-2*b -: 2];
    endfunction

    // Checks n back-to-back words with Rdy=1, starting with beat 0 on the lane
    task automatic check_stream(input string tag, input logic [11:0] wl [8], input int n);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 6; b++) begin
                chk({tag, "_sval"}, 32'(Sval), 32'd1);
                chk({tag, "_sdat"}, 32'(Sdat), 32'(beat_of(wl[k], b)));
                chk({tag, "_sfrm"}, 32'(Sfrm), (b == 0) ? 32'd1 : 32'd0);
                tick();
            end
        end
    endtask

    initial begin
        rstn = 1'b0; Vld = 1'b0; Dout = '0; Rdy = 1'b0; ClrOvf = 1'b0;
        repeat (2) tick();
        chk("rst_sval", 32'(Sval), 32'd0);
        chk("rst_sfrm", 32'(Sfrm), 32'd0);
        chk("rst_sdat", 32'(Sdat), 32'd0);
        chk("rst_ovf",  32'(Ovf),  32'd0);
        chk("rst_lvl",  32'(Lvl),  32'd0);
        rstn = 1'b1;
        tick();
        chk("idle_sval", 32'(Sval), 32'd0);

        // 1: single word A5C
        Rdy = 1'b1; Vld = 1'b1; Dout = 12'hA5C;
        tick();
        Vld = 1'b0;
        chk("t1_lvl_push", 32'(Lvl), 32'd1);
        chk("t1_sval_lat1", 32'(Sval), 32'd0);
        tick();
        for (int b = 0; b < 6; b++) begin
            chk("t1_sval", 32'(Sval), 32'd1);
            chk("t1_sdat", 32'(Sdat), 32'(exp1[b]));
            chk("t1_sfrm", 32'(Sfrm), (b == 0) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t1_sval_end", 32'(Sval), 32'd0);
        chk("t1_lvl_end",  32'(Lvl),  32'd0);

        // 2: FFF then 001 three cycles later, no bubble between words
        Vld = 1'b1; Dout = 12'hFFF;
        tick();
        Vld = 1'b0;
        tick();
        for (int b = 0; b < 12; b++) begin
            chk("t2_sval", 32'(Sval), 32'd1);
            chk("t2_sdat", 32'(Sdat), 32'(exp2[b]));
            chk("t2_sfrm", 32'(Sfrm), (b == 0 || b == 6) ? 32'd1 : 32'd0);
            if (b == 1) begin
                Vld = 1'b1; Dout = 12'h001;
            end else begin
                Vld = 1'b0;
            end
            tick();
        end
        chk("t2_sval_end", 32'(Sval), 32'd0);

        // 3: word 800 with a 3-cycle stall at beat 2
        Vld = 1'b1; Dout = 12'h800;
        tick();
        Vld = 1'b0;
        tick();
        begin
            int b;
            b = 0;
            for (int c = 0; c < 9; c++) begin
                Rdy = !(c >= 2 && c <= 4);
                chk("t3_sval", 32'(Sval), 32'd1);
                chk("t3_sdat", 32'(Sdat), 32'(exp3[b]));
                chk("t3_sfrm", 32'(Sfrm), (b == 0) ? 32'd1 : 32'd0);
                tick();
                if (Rdy) b++;
            end
        end
        Rdy = 1'b1;
        chk("t3_sval_end", 32'(Sval), 32'd0);

        // 4: overflow with Rdy low, then drain in order
        Rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            Vld = 1'b1; Dout = 12'(i);
            tick();
        end
        Vld = 1'b0;
        chk("t4_lvl_full", 32'(Lvl),  32'd4);
        chk("t4_ovf_set",  32'(Ovf),  32'd1);
        chk("t4_sval",     32'(Sval), 32'd1);
        chk("t4_sfrm_hold", 32'(Sfrm), 32'd1);
        Rdy = 1'b1;
        for (int i = 0; i < 5; i++) ws[i] = 12'(i + 1);
        check_stream("t4", ws, 5);
        chk("t4_sval_end", 32'(Sval), 32'd0);
        chk("t4_ovf_sticky", 32'(Ovf), 32'd1);
        ClrOvf = 1'b1;
        tick();
        ClrOvf = 1'b0;
        chk("t4_ovf_clr", 32'(Ovf), 32'd0);

        // 5: push and pop at full on the last beat
        Rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            Vld = 1'b1; Dout = 12'h100 + 12'(i);
            tick();
        end
        Vld = 1'b0;
        chk("t5_lvl_full", 32'(Lvl), 32'd4);
        Rdy = 1'b1;
        for (int b = 0; b < 5; b++) begin
            chk("t5_sdat_w0", 32'(Sdat), 32'(beat_of(12'h101, b)));
            tick();
        end
        chk("t5_sdat_last", 32'(Sdat), 32'(beat_of(12'h101, 5)));
        Vld = 1'b1; Dout = 12'h123;
        tick();
        Vld = 1'b0;
        chk("t5_lvl_same", 32'(Lvl), 32'd4);
        chk("t5_ovf_clear", 32'(Ovf), 32'd0);
        ws[0] = 12'h102; ws[1] = 12'h103; ws[2] = 12'h104; ws[3] = 12'h105; ws[4] = 12'h123;
        check_stream("t5", ws, 5);
        chk("t5_sval_end", 32'(Sval), 32'd0);
        chk("t5_lvl_end",  32'(Lvl),  32'd0);

        // 6: reset mid-word with two samples queued
        Vld = 1'b1; Dout = 12'h3C1;
        tick();
        Dout = 12'h3C2;
        tick();
        Dout = 12'h3C3;
        tick();
        Vld = 1'b0;
        tick();
        tick();
        chk("t6_lvl_pre",  32'(Lvl),  32'd2);
        chk("t6_sdat_b3",  32'(Sdat), 32'(beat_of(12'h3C1, 3)));
        #1 rstn = 1'b0;
        #1;
        chk("t6_sval_rst", 32'(Sval), 32'd0);
        chk("t6_lvl_rst",  32'(Lvl),  32'd0);
        chk("t6_sfrm_rst", 32'(Sfrm), 32'd0);
        tick();
        rstn = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (Sval) seen++;
            end
            chk("t6_quiet", 32'(seen), 32'd0);
        end
        chk("t6_lvl_quiet", 32'(Lvl), 32'd0);
        Vld = 1'b1; Dout = 12'h0F0;
        tick();
        Vld = 1'b0;
        tick();
        ws[0] = 12'h0F0;
        check_stream("t6", ws, 1);
        chk("t6_sval_end", 32'(Sval), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_nco_dout_serializer
`default_nettype wire
